// File: rtl/fifo_push_arbiter.sv
// Packet-aware round-robin arbiter that shares one FIFO push port among NUM_REQ producers.
// Optional stall watchdog is built when FIFO_ARB_WATCHDOG_EN is defined.
module fifo_push_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 4,
  parameter int FIFO_DEPTH  = 1 << ADDR_WIDTH,
  parameter int SRC_WIDTH   = 3,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ADDR_WIDTH:0]           fifo_count,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [SRC_WIDTH-1:0]          fifo_src,
  output logic [SRC_WIDTH-1:0]          owner,
  output logic                          busy,
  output logic                          wdog_err
);
  localparam int OCC_W = ADDR_WIDTH + 2;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [SRC_WIDTH-1:0]  owner_next;
  logic [SRC_WIDTH-1:0]  last_owner_reg, last_owner_next;
  logic [SRC_WIDTH-1:0]  grant_idx;
  logic [NUM_REQ-1:0]    owner_sel, upper_mask, upper_req;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [OCC_W-1:0]      occupancy;
  logic                  space_ok, owner_last, accept, wdog_fire;

  // The push already in flight is not yet visible in fifo_count, so count it here.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(fifo_push);
  assign space_ok  = occupancy < OCC_W'(FIFO_DEPTH);
  assign busy      = (state_reg == LOCKED);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign owner_sel[gi]  = (owner == SRC_WIDTH'(gi));
      assign upper_mask[gi] = (SRC_WIDTH'(gi) > last_owner_reg);
      assign req_ready[gi]  = busy & owner_sel[gi] & space_ok;
    end
  endgenerate

  assign upper_req  = req_valid & upper_mask;
  assign owner_last = |(req_last & owner_sel);
  assign accept     = |(req_valid & req_ready);

  // Round robin: lowest valid index above last_owner, else wrap to lowest valid index.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) grant_idx = SRC_WIDTH'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper_req[i]) grant_idx = SRC_WIDTH'(i);
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_sel[i]) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt_reg, wdog_cnt_next;
  logic            wdog_err_reg;
  logic            owner_valid;

  assign owner_valid = |(req_valid & owner_sel);

  // Only cycles where the owner shows no valid count as a stall; throttled cycles hold.
  always_comb begin
    wdog_cnt_next = '0;
    wdog_fire     = 1'b0;
    if (busy && !accept) begin
      if (owner_valid) begin
        wdog_cnt_next = wdog_cnt_reg;
      end else if (wdog_cnt_reg == WD_W'(WDOG_CYCLES - 1)) begin
        wdog_fire = 1'b1;
      end else begin
        wdog_cnt_next = wdog_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_next;
      wdog_err_reg <= wdog_fire;
    end
  end

  assign wdog_err = wdog_err_reg;
`else
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          owner_next = grant_idx;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if ((accept && owner_last) || wdog_fire) begin
          state_next      = IDLE;
          last_owner_next = owner;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      owner          <= '0;
      last_owner_reg <= SRC_WIDTH'(NUM_REQ - 1);
      fifo_push      <= 1'b0;
      fifo_data      <= '0;
      fifo_src       <= '0;
    end else begin
      state_reg      <= state_next;
      owner          <= owner_next;
      last_owner_reg <= last_owner_next;
      fifo_push      <= accept;
      if (accept) begin
        fifo_data <= owner_data;
        fifo_src  <= owner;
      end
    end
  end

endmodule
